// File: rtl/ram_port_arbiter.sv
`timescale 1ns/1ps
// ram_port_arbiter: serialises CPU and I/O-DMA accesses onto one single-port RAM (IDLE/ISSUE/WAIT).
// Optional macro ROUND_ROBIN_EN: alternate ports on contention; undefined = fixed CPU-over-I/O priority.
module ram_port_arbiter #(
  parameter int AW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          io_req,
  input  logic          io_we,
  input  logic [AW-1:0] io_addr,
  input  logic [7:0]    io_wdata,
  input  logic          io_lock,
  output logic [7:0]    io_rdata,
  output logic          io_ack,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic [1:0]    grant_q, grant_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]    ram_wdata_q, ram_wdata_d;
  logic          ram_we_q, ram_we_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic [7:0]    io_rdata_q, io_rdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          io_ack_q, io_ack_d;
  logic          lock_pend_q, lock_pend_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_ok, io_pref, io_wins, any_req;

  assign any_req = cpu_req | io_req;
  assign lock_ok = lock_pend_q && (lock_cnt_q < CW'(MAX_LOCK));

`ifdef ROUND_ROBIN_EN
  logic rr_io_q, rr_io_d;

  // A pending lock decides on its own; the pointer only breaks plain contention.
  assign io_pref = rr_io_q & ~lock_pend_q;

  always_comb begin
    rr_io_d = rr_io_q;
    if (state_q == IDLE && any_req) rr_io_d = ~io_wins;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_io_q <= 1'b0;
    else     rr_io_q <= rr_io_d;
  end
`else
  assign io_pref = 1'b0;
`endif

  assign io_wins = io_req && (!cpu_req || lock_ok || io_pref);

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    grant_d     = grant_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = ram_we_q;
    cpu_rdata_d = cpu_rdata_q;
    io_rdata_d  = io_rdata_q;
    cpu_ack_d   = 1'b0;
    io_ack_d    = 1'b0;
    lock_pend_d = lock_pend_q;
    lock_cnt_d  = lock_cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          if (io_wins) begin
            grant_d     = 2'b10;
            ram_addr_d  = io_addr;
            ram_wdata_d = io_wdata;
            ram_we_d    = io_we;
            if (lock_ok) lock_cnt_d = lock_cnt_q + CW'(1);
          end else begin
            grant_d     = 2'b01;
            ram_addr_d  = cpu_addr;
            ram_wdata_d = cpu_wdata;
            ram_we_d    = cpu_we;
            lock_pend_d = 1'b0;
            lock_cnt_d  = '0;
          end
        end
      end
      ISSUE: begin
        state_d   = WAIT;
        lat_cnt_d = 3'(RD_LAT);
      end
      WAIT: begin
        if (lat_cnt_q == 3'd1) begin
          state_d = IDLE;
          grant_d = 2'b00;
          if (grant_q[1]) begin
            io_ack_d    = 1'b1;
            lock_pend_d = io_lock;
            if (!io_lock) lock_cnt_d = '0;
            if (!ram_we_q) io_rdata_d = ram_rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (!ram_we_q) cpu_rdata_d = ram_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= '0;
      grant_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      cpu_rdata_q <= '0;
      io_rdata_q  <= '0;
      cpu_ack_q   <= 1'b0;
      io_ack_q    <= 1'b0;
      lock_pend_q <= 1'b0;
      lock_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      grant_q     <= grant_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      cpu_rdata_q <= cpu_rdata_d;
      io_rdata_q  <= io_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      io_ack_q    <= io_ack_d;
      lock_pend_q <= lock_pend_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  // ram_en decodes straight from state so a reset drops it without waiting for an edge.
  assign ram_en    = (state_q == ISSUE);
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign io_rdata  = io_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign io_ack    = io_ack_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for ram_port_arbiter: RAM models with exact read latency, directed
// scenarios per feature, and randomized two-port traffic checked against a memory reference.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, io_req = 0, io_we = 0, io_lock = 0;
  logic [15:0] cpu_addr = '0, io_addr = '0;
  logic [7:0]  cpu_wdata = '0, io_wdata = '0;
  logic [7:0]  cpu_rdata, io_rdata, ram_wdata, ram_rdata;
  logic        cpu_ack, cpu_stall, io_ack, ram_en, ram_we, busy;
  logic [15:0] ram_addr;
  logic [1:0]  grant;

  logic        l4_cpu_req = 0, l4_cpu_we = 0, l4_io_req = 0, l4_io_we = 0, l4_io_lock = 0;
  logic [15:0] l4_cpu_addr = '0, l4_io_addr = '0;
  logic [7:0]  l4_cpu_wdata = '0, l4_io_wdata = '0;
  logic [7:0]  l4_cpu_rdata, l4_io_rdata, l4_ram_wdata, l4_ram_rdata;
  logic        l4_cpu_ack, l4_cpu_stall, l4_io_ack, l4_ram_en, l4_ram_we, l4_busy;
  logic [15:0] l4_ram_addr;
  logic [1:0]  l4_grant;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(16), .RD_LAT(1), .MAX_LOCK(4)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_lock(io_lock),
    .io_rdata(io_rdata), .io_ack(io_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .grant(grant), .busy(busy)
  );

  ram_port_arbiter #(.AW(16), .RD_LAT(4), .MAX_LOCK(4)) u_dut_lat4 (
    .clk(clk), .rst(rst),
    .cpu_req(l4_cpu_req), .cpu_we(l4_cpu_we), .cpu_addr(l4_cpu_addr), .cpu_wdata(l4_cpu_wdata),
    .cpu_rdata(l4_cpu_rdata), .cpu_ack(l4_cpu_ack), .cpu_stall(l4_cpu_stall),
    .io_req(l4_io_req), .io_we(l4_io_we), .io_addr(l4_io_addr), .io_wdata(l4_io_wdata),
    .io_lock(l4_io_lock), .io_rdata(l4_io_rdata), .io_ack(l4_io_ack),
    .ram_en(l4_ram_en), .ram_we(l4_ram_we), .ram_addr(l4_ram_addr), .ram_wdata(l4_ram_wdata),
    .ram_rdata(l4_ram_rdata), .grant(l4_grant), .busy(l4_busy)
  );

  // Preloaded RAM contents; chosen so that address 0x1234 holds 0xA5.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h83;
  endfunction

  // RAM models: data is driven only in the exact cycle the latency allows, 0xEE otherwise.
  logic [7:0] mem [logic [15:0]];
  logic [7:0] rd_pipe;
  logic       rd_vld;
  always @(posedge clk) begin
    if (rst) rd_vld <= 1'b0;
    else     rd_vld <= ram_en & ~ram_we;
    rd_pipe <= mem.exists(ram_addr) ? mem[ram_addr] : init_val(ram_addr);
    if (ram_en && ram_we) mem[ram_addr] = ram_wdata;
  end
  assign ram_rdata = rd_vld ? rd_pipe : 8'hEE;

  logic [7:0] l4_pipe [0:3];
  logic [3:0] l4_vld;
  always @(posedge clk) begin
    if (rst) l4_vld <= '0;
    else     l4_vld <= {l4_vld[2:0], l4_ram_en & ~l4_ram_we};
    l4_pipe[0] <= init_val(l4_ram_addr);
    for (int k = 1; k < 4; k++) l4_pipe[k] <= l4_pipe[k-1];
  end
  assign l4_ram_rdata = l4_vld[3] ? l4_pipe[3] : 8'hEE;

  // Monitor: every RAM strobe must carry exactly one owner and that owner's payload.
  logic [1:0] grant_log [$];
  logic       last_en_we;
  always @(negedge clk) begin
    if (ram_en === 1'b1) begin
      grant_log.push_back(grant);
      last_en_we = ram_we;
      checks++;
      if (grant === 2'b01) begin
        if ({ram_addr, ram_we, ram_we ? ram_wdata : 8'h0} !==
            {cpu_addr, cpu_we, cpu_we ? cpu_wdata : 8'h0}) begin
          errors++;
          $display("FAIL mon_cpu_payload: ram addr=%h we=%b wd=%h required addr=%h we=%b wd=%h",
                   ram_addr, ram_we, ram_wdata, cpu_addr, cpu_we, cpu_wdata);
        end
      end else if (grant === 2'b10) begin
        if ({ram_addr, ram_we, ram_we ? ram_wdata : 8'h0} !==
            {io_addr, io_we, io_we ? io_wdata : 8'h0}) begin
          errors++;
          $display("FAIL mon_io_payload: ram addr=%h we=%b wd=%h required addr=%h we=%b wd=%h",
                   ram_addr, ram_we, ram_wdata, io_addr, io_we, io_wdata);
        end
      end else begin
        errors++;
        $display("FAIL mon_grant_onehot: grant=%b during ram_en, required 01 or 10", grant);
      end
    end
  end

  // Reference memory for the randomized traffic (updated when a write is acknowledged).
  logic [7:0] ref_mem [logic [15:0]];
  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Expected winner when both ports request with no lock pending.
  function automatic logic [1:0] exp_first(input bit last_cpu);
`ifdef ROUND_ROBIN_EN
    return last_cpu ? 2'b10 : 2'b01;
`else
    return 2'b01;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_xact(input logic we, input logic [15:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1; lat = 0;
    do begin
      tick();
      lat++;
    end while (cpu_ack !== 1'b1 && lat < 40);
    checks++;
    if (cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL cpu_timeout: addr=%h ack=%b required 1 within 40 cycles", a, cpu_ack);
    end
    rd = cpu_rdata;
    cpu_req = 1'b0;
    $display("cpu %s addr=%h data=%h lat=%0d", we ? "wr" : "rd", a, we ? d : rd, lat);
  endtask

  task automatic io_xact(input logic we, input logic [15:0] a, input logic [7:0] d,
                         input logic lk, input bit keep, output logic [7:0] rd, output int lat);
    io_we = we; io_addr = a; io_wdata = d; io_lock = lk; io_req = 1'b1; lat = 0;
    do begin
      tick();
      lat++;
    end while (io_ack !== 1'b1 && lat < 40);
    checks++;
    if (io_ack !== 1'b1) begin
      errors++;
      $display("FAIL io_timeout: addr=%h ack=%b required 1 within 40 cycles", a, io_ack);
    end
    rd = io_rdata;
    if (!keep) io_req = 1'b0;
    $display("io  %s addr=%h data=%h lat=%0d lock=%b", we ? "wr" : "rd", a, we ? d : rd, lat, lk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({ram_en, ram_we, busy, cpu_ack, io_ack, cpu_stall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: en/we/busy/cack/iack/stall=%b required 000000",
               {ram_en, ram_we, busy, cpu_ack, io_ack, cpu_stall});
    end
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL reset_grant: grant=%b required 00", grant);
    end
    checks++;
    if ({ram_addr, ram_wdata, cpu_rdata, io_rdata} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wd=%h crd=%h ird=%h required all 0",
               ram_addr, ram_wdata, cpu_rdata, io_rdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
    #1;
    checks++;
    if ({cpu_stall, ram_en} !== 2'b10) begin
      errors++;
      $display("FAIL rd_before_edge: stall,ram_en=%b required 10", {cpu_stall, ram_en});
    end
    tick();
    checks++;
    if ({ram_en, grant, busy, ram_addr} !== {1'b1, 2'b01, 1'b1, 16'h1234}) begin
      errors++;
      $display("FAIL rd_issue: en=%b grant=%b busy=%b addr=%h required 1 01 1 1234",
               ram_en, grant, busy, ram_addr);
    end
    tick();
    checks++;
    if ({ram_en, cpu_ack, cpu_stall} !== 3'b001) begin
      errors++;
      $display("FAIL rd_wait: en,ack,stall=%b required 001", {ram_en, cpu_ack, cpu_stall});
    end
    tick();
    checks++;
    if ({cpu_ack, cpu_rdata, grant, cpu_stall} !== {1'b1, 8'hA5, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL rd_ack: ack=%b rdata=%h grant=%b stall=%b required 1 a5 00 0",
               cpu_ack, cpu_rdata, grant, cpu_stall);
    end
    cpu_req = 1'b0;
    $display("cpu rd addr=1234 data=%h lat=3", cpu_rdata);
    tick();
    checks++;
    if ({cpu_ack, busy, cpu_rdata} !== {1'b0, 1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL rd_after_ack: ack=%b busy=%b rdata=%h required 0 0 a5", cpu_ack, busy, cpu_rdata);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd;
    int lat;
    cpu_xact(1'b1, 16'h0010, 8'h3C, rd, lat);
    checks++;
    if ({last_en_we, lat} !== {1'b1, 32'd3}) begin
      errors++;
      $display("FAIL wr_strobe: ram_we=%b lat=%0d required 1 and 3", last_en_we, lat);
    end
    cpu_xact(1'b0, 16'h0010, 8'h00, rd, lat);
    checks++;
    if ({last_en_we, rd} !== {1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL wr_readback: ram_we=%b rdata=%h required 0 3c", last_en_we, rd);
    end
  endtask

  task automatic test_priority();
    logic [7:0] crd, ird;
    int clat, ilat;
    logic [1:0] exp0;
    bit last_cpu;
    apply_reset();
    cpu_xact(1'b0, 16'h0005, 8'h00, crd, clat);
    last_cpu = 1'b1;
    for (int round = 0; round < 2; round++) begin
      exp0 = exp_first(last_cpu);
      grant_log.delete();
      fork
        cpu_xact(1'b0, 16'h0007 + 16'(round), 8'h00, crd, clat);
        io_xact(1'b0, 16'h8007 + 16'(round), 8'h00, 1'b0, 1'b0, ird, ilat);
      join
      checks++;
      if (grant_log.size() != 2 || grant_log[0] !== exp0 || grant_log[1] !== ~exp0) begin
        errors++;
        $display("FAIL prio_order round %0d: count=%0d first=%b required 2 grants, first %b",
                 round, grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 2'bxx, exp0);
      end
      checks++;
      if ((exp0 == 2'b01 ? {clat, ilat} : {ilat, clat}) !== {32'd3, 32'd6}) begin
        errors++;
        $display("FAIL prio_latency round %0d: cpu=%0d io=%0d required winner 3 loser 6",
                 round, clat, ilat);
      end
      checks++;
      if ({crd, ird} !== {init_val(16'h0007 + 16'(round)), init_val(16'h8007 + 16'(round))}) begin
        errors++;
        $display("FAIL prio_data round %0d: cpu=%h io=%h required %h %h", round, crd, ird,
                 init_val(16'h0007 + 16'(round)), init_val(16'h8007 + 16'(round)));
      end
      last_cpu = (exp0 != 2'b01);
    end
  endtask

  task automatic test_lock();
    logic [1:0] exp_q [$];
    logic [7:0] crd;
    int clat;
    int io_left, cpu_left, cnt;
    bit locked, first;
    apply_reset();
    grant_log.delete();
    fork
      begin : io_burst
        logic [7:0] ird;
        int ilat;
        for (int i = 0; i < 6; i++) begin
          io_xact(1'b0, 16'h8100 + 16'(i), 8'h00, 1'b1, i < 5, ird, ilat);
          checks++;
          if (ird !== init_val(16'h8100 + 16'(i))) begin
            errors++;
            $display("FAIL lock_io_data %0d: rdata=%h required %h", i, ird, init_val(16'h8100 + 16'(i)));
          end
        end
      end
      begin : cpu_side
        tick();
        cpu_xact(1'b0, 16'h0300, 8'h00, crd, clat);
      end
    join
    io_lock = 1'b0;
    // Expected grant order from the lock rule: I/O alone first, then locked I/O while count < 4.
    io_left = 6; cpu_left = 1; cnt = 0; locked = 0; first = 1;
    while (io_left > 0 || cpu_left > 0) begin
      if (io_left > 0 && (first || cpu_left == 0 || (locked && cnt < 4))) begin
        exp_q.push_back(2'b10);
        if (locked && cnt < 4) cnt++;
        locked = 1;
        io_left--;
      end else begin
        exp_q.push_back(2'b01);
        cnt = 0;
        locked = 0;
        cpu_left--;
      end
      first = 0;
    end
    checks++;
    if (grant_log.size() != exp_q.size()) begin
      errors++;
      $display("FAIL lock_count: grants=%0d required %0d", grant_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (grant_log[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL lock_order %0d: grant=%b required %b", i, grant_log[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (crd !== init_val(16'h0300)) begin
      errors++;
      $display("FAIL lock_cpu_data: rdata=%h required %h", crd, init_val(16'h0300));
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd;
    int lat;
    cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_req = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, ram_en} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_in_wait: busy,en=%b required 10", {busy, ram_en});
    end
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    checks++;
    if ({ram_en, ram_we, busy, grant, cpu_ack, io_ack, cpu_stall, ram_addr, cpu_rdata, io_rdata} !== 0) begin
      errors++;
      $display("FAIL rstmid_outputs: en=%b busy=%b grant=%b ack=%b addr=%h crd=%h ird=%h required all 0",
               ram_en, busy, grant, cpu_ack, ram_addr, cpu_rdata, io_rdata);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({cpu_ack, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_no_ack: ack=%b busy=%b required 0 0", cpu_ack, busy);
    end
    cpu_xact(1'b0, 16'h1234, 8'h00, rd, lat);
    checks++;
    if ({rd, lat} !== {8'hA5, 32'd3}) begin
      errors++;
      $display("FAIL rstmid_recover: rdata=%h lat=%0d required a5 3", rd, lat);
    end
  endtask

  task automatic test_stall_lat4();
    int n = 0;
    int g = 0;
    l4_cpu_addr = 16'h1234;
    l4_cpu_req = 1'b1;
    #1;
    while (l4_cpu_ack !== 1'b1 && g < 20) begin
      if (l4_cpu_stall === 1'b1) n++;
      tick();
      g++;
      if (g == 1) begin
        checks++;
        if ({l4_grant, l4_busy, l4_ram_we, l4_ram_en} !== 5'b01101) begin
          errors++;
          $display("FAIL lat4_issue: grant=%b busy=%b we=%b en=%b required 01 1 0 1",
                   l4_grant, l4_busy, l4_ram_we, l4_ram_en);
        end
      end
    end
    checks++;
    if (n != 6 || l4_cpu_ack !== 1'b1) begin
      errors++;
      $display("FAIL lat4_stall_cycles: stall=%0d ack=%b required 6 then ack 1", n, l4_cpu_ack);
    end
    checks++;
    if ({l4_cpu_stall, l4_cpu_rdata} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL lat4_ack_cycle: stall=%b rdata=%h required 0 a5", l4_cpu_stall, l4_cpu_rdata);
    end
    l4_cpu_req = 1'b0;
    $display("cpu rd addr=1234 data=%h lat=%0d (RD_LAT=4 port)", l4_cpu_rdata, g);
    tick();
    checks++;
    if ({l4_io_ack, l4_io_rdata, l4_ram_wdata, l4_cpu_ack} !== 18'h0) begin
      errors++;
      $display("FAIL lat4_idle: io_ack=%b io_rdata=%h wdata=%h cpu_ack=%b required all 0",
               l4_io_ack, l4_io_rdata, l4_ram_wdata, l4_cpu_ack);
    end
  endtask

  task automatic test_random();
    fork
      begin : cpu_side
        logic [15:0] a;
        logic [7:0] d, rd;
        logic we;
        int lat;
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          a = 16'h0200 + 16'($urandom_range(0, 7));
          we = 1'($urandom_range(0, 1));
          d = 8'($urandom);
          cpu_xact(we, a, d, rd, lat);
          checks++;
          if (lat < 3 || lat > 6 || (!we && rd !== ref_rd(a))) begin
            errors++;
            $display("FAIL rand_cpu %0d: addr=%h rdata=%h lat=%0d required %h lat 3..6",
                     i, a, rd, lat, ref_rd(a));
          end
          if (we) ref_mem[a] = d;
        end
      end
      begin : io_side
        logic [15:0] a;
        logic [7:0] d, rd;
        logic we;
        int lat;
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          a = 16'h8200 + 16'($urandom_range(0, 7));
          we = 1'($urandom_range(0, 1));
          d = 8'($urandom);
          io_xact(we, a, d, 1'b0, 1'b0, rd, lat);
          checks++;
          if (lat < 3 || (!we && rd !== ref_rd(a))) begin
            errors++;
            $display("FAIL rand_io %0d: addr=%h rdata=%h lat=%0d required %h lat>=3",
                     i, a, rd, lat, ref_rd(a));
          end
          if (we) ref_mem[a] = d;
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_write_read();
    test_priority();
    test_lock();
    test_reset_mid();
    test_stall_lat4();
    test_random();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
